// File: rtl/jt89_pkg.sv
// Shared types and limits for the jt89 PSG write buffer.
package jt89_pkg;

    // Output sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StLow   = 2'd2,
        StGap   = 2'd3
    } wr_state_e;

    localparam int unsigned LowCycDefault = 2;
    localparam int unsigned GapCycDefault = 2;

    // FIFO depth must be a power of two inside these limits
    localparam int unsigned DepthMin = 2;
    localparam int unsigned DepthMax = 64;

    // Tick counter width, wide enough for LOW_CYC/GAP_CYC up to 15
    localparam int unsigned TickW = 4;

endpackage

// File: rtl/jt89_wrfifo.sv
// Byte FIFO for the jt89 write buffer: storage array, wrapping pointers and
// an occupancy count. Full/empty come from the registered count only, so a
// push while full is refused even if a pop happens in the same cycle.
module jt89_wrfifo import jt89_pkg::*; #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       pop_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [7:0]      mem_q [DEPTH];
    logic            push_ok, pop_ok;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Next pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; writes during reset are ignored
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/jt89_wrbuf.sv
// CPU-to-PSG write buffer. CPU bytes are queued at full clk rate and replayed
// to the PSG as SETUP / LOW / GAP strobes that advance only on clk_en ticks.
// Define JT89_WRBUF_STATS_EN to get a saturating dropped-write counter on
// ovf_cnt; otherwise ovf_cnt is tied to zero.
module jt89_wrbuf import jt89_pkg::*; #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned LOW_CYC = LowCycDefault,
    parameter int unsigned GAP_CYC = GapCycDefault
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cpu_we,
    input  logic [7:0] cpu_din,
    output logic       cpu_full,
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] ovf_cnt
);

    localparam logic [TickW-1:0] LowLast = TickW'(LOW_CYC - 1);
    localparam logic [TickW-1:0] GapLast = TickW'(GAP_CYC - 1);

    wr_state_e        state_q;
    logic [TickW-1:0] tick_q;
    logic             psg_wr_n_q;
    logic [7:0]       psg_din_q;
    logic             overflow_q;
    logic             fifo_pop, fifo_empty, fifo_full;
    logic [7:0]       fifo_head;
    logic             drop;

    // Head entry leaves the queue on the tick that ends the LOW phase
    assign fifo_pop = clk_en && (state_q == StLow) && (tick_q == LowLast);
    assign drop     = cpu_we & fifo_full;

    jt89_wrfifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cpu_we),
        .din_i   (cpu_din),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Output sequencer: state, tick counter and registered PSG strobe/data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tick_q     <= '0;
            psg_wr_n_q <= 1'b1;
            psg_din_q  <= 8'h00;
        end else if (clk_en) begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        state_q   <= StSetup;
                        psg_din_q <= fifo_head;
                    end
                end
                StSetup: begin
                    state_q    <= StLow;
                    psg_wr_n_q <= 1'b0;
                    tick_q     <= '0;
                end
                StLow: begin
                    if (tick_q == LowLast) begin
                        state_q    <= StGap;
                        psg_wr_n_q <= 1'b1;
                        tick_q     <= '0;
                    end else begin
                        tick_q <= tick_q + TickW'(1);
                    end
                end
                StGap: begin
                    if (tick_q == GapLast) begin
                        tick_q <= '0;
                        if (!fifo_empty) begin
                            state_q   <= StSetup;
                            psg_din_q <= fifo_head;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        tick_q <= tick_q + TickW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sticky flag for any write refused because the queue was full
    always_ff @(posedge clk) begin
        if (rst)       overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

`ifdef JT89_WRBUF_STATS_EN
    logic [7:0] ovf_cnt_q;

    // Dropped-write counter, saturating at 255
    always_ff @(posedge clk) begin
        if (rst)                             ovf_cnt_q <= 8'h00;
        else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = 8'h00;
`endif

    assign cpu_full = fifo_full;
    assign psg_wr_n = psg_wr_n_q;
    assign psg_din  = psg_din_q;
    assign overflow = overflow_q;
    assign busy     = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_jt89_wrbuf.sv
// Directed bench for jt89_wrbuf: default instance (LOW_CYC=2) plus a second
// instance with LOW_CYC=3 for the slow clock-enable case.
module tb_jt89_wrbuf;

`ifdef JT89_WRBUF_STATS_EN
    localparam int StatsEn = 1;
`else
    localparam int StatsEn = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       clk_en = 1'b0, cpu_we = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic       cpu_full, psg_wr_n, busy, overflow;
    logic [7:0] psg_din, ovf_cnt;

    logic       clk_en3 = 1'b0, cpu_we3 = 1'b0;
    logic [7:0] cpu_din3 = 8'h00;
    logic       cpu_full3, psg_wr_n3, busy3, overflow3;
    logic [7:0] psg_din3, ovf_cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    jt89_wrbuf #(.DEPTH(8), .LOW_CYC(2), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .cpu_we(cpu_we), .cpu_din(cpu_din),
        .cpu_full(cpu_full), .psg_wr_n(psg_wr_n), .psg_din(psg_din), .busy(busy),
        .overflow(overflow), .ovf_cnt(ovf_cnt)
    );

    jt89_wrbuf #(.DEPTH(8), .LOW_CYC(3), .GAP_CYC(2)) dut3 (
        .clk(clk), .rst(rst), .clk_en(clk_en3), .cpu_we(cpu_we3), .cpu_din(cpu_din3),
        .cpu_full(cpu_full3), .psg_wr_n(psg_wr_n3), .psg_din(psg_din3), .busy(busy3),
        .overflow(overflow3), .ovf_cnt(ovf_cnt3)
    );

    // Pulse monitor on the default instance: bytes, low lengths, high gaps
    logic       mon_prev = 1'b1;
    bit         have_pulse = 1'b0;
    int         high_len = 0, low_len = 0, din_unstable = 0;
    logic [7:0] low_din = 8'h00;
    logic [7:0] pulse_q[$];
    int         len_q[$];
    int         gap_q[$];

    always @(negedge clk) begin
        if (mon_prev && !psg_wr_n) begin
            if (have_pulse) gap_q.push_back(high_len);
            pulse_q.push_back(psg_din);
            low_din    = psg_din;
            low_len    = 1;
            have_pulse = 1'b1;
        end else if (!psg_wr_n) begin
            low_len++;
            if (psg_din !== low_din) din_unstable++;
        end else if (!mon_prev) begin
            len_q.push_back(low_len);
            high_len = 1;
        end else begin
            high_len++;
        end
        mon_prev = psg_wr_n;
    end

    task automatic clear_mon();
        pulse_q.delete();
        len_q.delete();
        gap_q.delete();
        have_pulse   = 1'b0;
        din_unstable = 0;
        high_len     = 0;
        low_len      = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1; cpu_we = 1'b0; cpu_we3 = 1'b0; clk_en = 1'b0; clk_en3 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(posedge clk);
        #1 cpu_we = 1'b1; cpu_din = b;
        @(posedge clk);
        #1 cpu_we = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int c = 0;
        @(negedge clk);
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy=%0b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1 rst = 1'b1; cpu_we = 1'b1; cpu_din = 8'h55; cpu_we3 = 1'b1; cpu_din3 = 8'h66;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; cpu_we = 1'b0; cpu_we3 = 1'b0;
        @(negedge clk);
        n_tests++; if (psg_wr_n !== 1'b1) begin n_fail++;
            $display("FAIL reset_wr_n: got %0b required 1", psg_wr_n); end
        n_tests++; if (psg_din !== 8'h00) begin n_fail++;
            $display("FAIL reset_din: got %02h required 00", psg_din); end
        n_tests++; if (cpu_full !== 1'b0) begin n_fail++;
            $display("FAIL reset_full: got %0b required 0", cpu_full); end
        n_tests++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_busy: got %0b required 0", busy); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++;
            $display("FAIL reset_overflow: got %0b required 0", overflow); end
        n_tests++; if (ovf_cnt !== 8'h00) begin n_fail++;
            $display("FAIL reset_ovf_cnt: got %0d required 0", ovf_cnt); end
        n_tests++; if ({psg_wr_n3, busy3, cpu_full3, overflow3} !== 4'b1000) begin n_fail++;
            $display("FAIL reset_dut3: wr_n/busy/full/ovf got %b required 1000",
                     {psg_wr_n3, busy3, cpu_full3, overflow3}); end
        n_tests++; if (ovf_cnt3 !== 8'h00) begin n_fail++;
            $display("FAIL reset_dut3_ovf_cnt: got %0d required 0", ovf_cnt3); end
        // The write presented during reset must not come out later
        clear_mon();
        clk_en = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++; if (pulse_q.size() != 0) begin n_fail++;
            $display("FAIL reset_write_ignored: pulses %0d required 0", pulse_q.size()); end
        n_tests++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL reset_write_busy: got %0b required 0", busy); end
        clk_en = 1'b0;
    endtask

    task automatic test_single_write();
        logic       exp_wr_n [7];
        logic [7:0] exp_din  [7];
        logic       exp_busy [7];
        exp_wr_n = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_din  = '{8'h00, 8'h9F, 8'h9F, 8'h9F, 8'h9F, 8'h9F, 8'h9F};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_mon();
        clk_en = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b1; cpu_din = 8'h9F;
        @(posedge clk);
        #1 cpu_we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            n_tests++; if (psg_wr_n !== exp_wr_n[i]) begin n_fail++;
                $display("FAIL single_wr_n[%0d]: got %0b required %0b", i, psg_wr_n, exp_wr_n[i]); end
            n_tests++; if (psg_din !== exp_din[i]) begin n_fail++;
                $display("FAIL single_din[%0d]: got %02h required %02h", i, psg_din, exp_din[i]); end
            n_tests++; if (busy !== exp_busy[i]) begin n_fail++;
                $display("FAIL single_busy[%0d]: got %0b required %0b", i, busy, exp_busy[i]); end
        end
        clk_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        clear_mon();
        clk_en = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b1; cpu_din = 8'h80;
        @(posedge clk);
        #1 cpu_din = 8'h3F;
        @(posedge clk);
        #1 cpu_we = 1'b0;
        wait_idle(100, "b2b");
        n_tests++; if (pulse_q.size() != 2) begin n_fail++;
            $display("FAIL b2b_pulses: got %0d required 2", pulse_q.size()); end
        if (pulse_q.size() >= 2 && len_q.size() >= 2 && gap_q.size() >= 1) begin
            n_tests++; if (pulse_q[0] !== 8'h80) begin n_fail++;
                $display("FAIL b2b_first: got %02h required 80", pulse_q[0]); end
            n_tests++; if (pulse_q[1] !== 8'h3F) begin n_fail++;
                $display("FAIL b2b_second: got %02h required 3F", pulse_q[1]); end
            n_tests++; if (len_q[0] != 2 || len_q[1] != 2) begin n_fail++;
                $display("FAIL b2b_low_len: got %0d,%0d required 2,2", len_q[0], len_q[1]); end
            n_tests++; if (gap_q[0] < 2) begin n_fail++;
                $display("FAIL b2b_gap: got %0d required >=2", gap_q[0]); end
        end
        clk_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic exp_full, exp_ovf;
        clear_mon();
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push_byte(8'(8'h10 + i));
            @(negedge clk);
            exp_full = (i >= 7);
            exp_ovf  = (i >= 8);
            n_tests++; if (cpu_full !== exp_full) begin n_fail++;
                $display("FAIL ovf_full[%0d]: got %0b required %0b", i, cpu_full, exp_full); end
            n_tests++; if (overflow !== exp_ovf) begin n_fail++;
                $display("FAIL ovf_flag[%0d]: got %0b required %0b", i, overflow, exp_ovf); end
        end
        n_tests++; if (ovf_cnt !== 8'(2 * StatsEn)) begin n_fail++;
            $display("FAIL ovf_cnt: got %0d required %0d", ovf_cnt, 2 * StatsEn); end
        n_tests++; if (psg_wr_n !== 1'b1 || busy !== 1'b1) begin n_fail++;
            $display("FAIL ovf_frozen: wr_n=%0b busy=%0b required 1,1", psg_wr_n, busy); end
        n_tests++; if (pulse_q.size() != 0) begin n_fail++;
            $display("FAIL ovf_no_pulse: got %0d required 0", pulse_q.size()); end
        @(posedge clk);
        #1 clk_en = 1'b1;
        wait_idle(300, "ovf_drain");
        n_tests++; if (pulse_q.size() != 8) begin n_fail++;
            $display("FAIL ovf_drain_count: got %0d required 8", pulse_q.size()); end
        for (int k = 0; k < 8 && k < pulse_q.size(); k++) begin
            n_tests++; if (pulse_q[k] !== 8'(8'h10 + k)) begin n_fail++;
                $display("FAIL ovf_drain_byte[%0d]: got %02h required %02h",
                         k, pulse_q[k], 8'(8'h10 + k)); end
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++;
            $display("FAIL ovf_sticky: got %0b required 1", overflow); end
        clk_en = 1'b0;
        do_reset();
        @(negedge clk);
        n_tests++; if (overflow !== 1'b0 || ovf_cnt !== 8'h00) begin n_fail++;
            $display("FAIL ovf_cleared: ovf=%0b cnt=%0d required 0,0", overflow, ovf_cnt); end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [7:0] exp_bytes [9];
        exp_bytes = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8};
        do_reset();
        // Advance both pointers to 5 so the next entries wrap past index 7
        for (int i = 0; i < 5; i++) push_byte(8'(8'h20 + i));
        clk_en = 1'b1;
        wait_idle(200, "pp_prefill");
        @(posedge clk);
        #1 clk_en = 1'b0;
        for (int i = 0; i < 4; i++) push_byte(8'(8'hB0 + i));
        clear_mon();
        clk_en = 1'b1;
        @(posedge clk);   // IDLE -> SETUP
        @(posedge clk);   // SETUP -> LOW
        @(posedge clk);   // LOW tick 0 -> 1
        #1 cpu_we = 1'b1; cpu_din = 8'hB4;
        @(posedge clk);   // LOW ends: pop and push together
        #1 cpu_we = 1'b0; clk_en = 1'b0;
        @(negedge clk);
        n_tests++; if (psg_wr_n !== 1'b1) begin n_fail++;
            $display("FAIL pp_wr_n_gap: got %0b required 1", psg_wr_n); end
        n_tests++; if (dut.u_fifo.count_q !== 4'd4) begin n_fail++;
            $display("FAIL pp_count: got %0d required 4", dut.u_fifo.count_q); end
        for (int i = 5; i < 8; i++) push_byte(8'(8'hB0 + i));
        @(negedge clk);
        n_tests++; if (cpu_full !== 1'b0) begin n_fail++;
            $display("FAIL pp_not_full_at7: got %0b required 0", cpu_full); end
        push_byte(8'hB8);
        @(negedge clk);
        n_tests++; if (cpu_full !== 1'b1 || overflow !== 1'b0) begin n_fail++;
            $display("FAIL pp_full_at8: full=%0b ovf=%0b required 1,0", cpu_full, overflow); end
        push_byte(8'hB9);
        @(negedge clk);
        n_tests++; if (overflow !== 1'b1 || ovf_cnt !== 8'(StatsEn)) begin n_fail++;
            $display("FAIL pp_drop: ovf=%0b cnt=%0d required 1,%0d", overflow, ovf_cnt, StatsEn); end
        @(posedge clk);
        #1 clk_en = 1'b1;
        wait_idle(300, "pp_drain");
        n_tests++; if (pulse_q.size() != 9) begin n_fail++;
            $display("FAIL pp_drain_count: got %0d required 9", pulse_q.size()); end
        for (int k = 0; k < 9 && k < pulse_q.size(); k++) begin
            n_tests++; if (pulse_q[k] !== exp_bytes[k]) begin n_fail++;
                $display("FAIL pp_byte[%0d]: got %02h required %02h", k, pulse_q[k], exp_bytes[k]); end
        end
        clk_en = 1'b0;
    endtask

    task automatic test_reset_during_low();
        int c = 0;
        do_reset();
        clear_mon();
        clk_en = 1'b1;
        @(posedge clk);
        #1 cpu_we = 1'b1; cpu_din = 8'h11;
        @(posedge clk);
        #1 cpu_din = 8'h22;
        @(posedge clk);
        #1 cpu_din = 8'h33;
        @(posedge clk);
        #1 cpu_we = 1'b0;
        @(negedge clk);
        while (psg_wr_n && c < 50) begin
            @(negedge clk);
            c++;
        end
        n_tests++; if (psg_wr_n !== 1'b0) begin n_fail++;
            $display("FAIL rlow_reach_low: wr_n=%0b required 0", psg_wr_n); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_tests++; if (psg_wr_n !== 1'b1) begin n_fail++;
            $display("FAIL rlow_wr_n: got %0b required 1", psg_wr_n); end
        n_tests++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL rlow_busy: got %0b required 0", busy); end
        n_tests++; if (psg_din !== 8'h00) begin n_fail++;
            $display("FAIL rlow_din: got %02h required 00", psg_din); end
        clear_mon();
        push_byte(8'hE4);
        wait_idle(100, "rlow_after");
        n_tests++; if (pulse_q.size() != 1) begin n_fail++;
            $display("FAIL rlow_pulses: got %0d required 1", pulse_q.size()); end
        if (pulse_q.size() >= 1) begin
            n_tests++; if (pulse_q[0] !== 8'hE4) begin n_fail++;
                $display("FAIL rlow_first_byte: got %02h required E4", pulse_q[0]); end
        end
        clk_en = 1'b0;
    endtask

    task automatic test_slow_clk_en();
        int   low_cnt = 0, unstable = 0, falls = 0;
        bit   done = 1'b0;
        logic prev = 1'b1;
        do_reset();
        @(posedge clk);
        #1 cpu_we3 = 1'b1; cpu_din3 = 8'h5A;
        @(posedge clk);
        #1 cpu_we3 = 1'b0;
        for (int c = 0; c < 600 && !done; c++) begin
            clk_en3 = (c % 16 == 0);
            @(negedge clk);
            if (prev && !psg_wr_n3) falls++;
            if (!psg_wr_n3) begin
                low_cnt++;
                if (psg_din3 !== 8'h5A) unstable++;
            end
            if (low_cnt > 0 && psg_wr_n3 && !busy3) done = 1'b1;
            prev = psg_wr_n3;
            @(posedge clk);
            #1;
        end
        clk_en3 = 1'b0;
        n_tests++; if (!done) begin n_fail++;
            $display("FAIL slow_timeout: done=%0b required 1", done); end
        n_tests++; if (low_cnt != 48) begin n_fail++;
            $display("FAIL slow_low_len: got %0d required 48", low_cnt); end
        n_tests++; if (unstable != 0) begin n_fail++;
            $display("FAIL slow_din_stable: unstable cycles %0d required 0", unstable); end
        n_tests++; if (falls != 1) begin n_fail++;
            $display("FAIL slow_pulse_count: got %0d required 1", falls); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_overflow();
        test_push_pop_same_cycle();
        test_reset_during_low();
        test_slow_clk_en();
        n_tests++; if (din_unstable != 0) begin n_fail++;
            $display("FAIL din_stable_during_low: got %0d required 0", din_unstable); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

endmodule
